// File: rtl/riscv_mem_responder.sv
// Memory responder for the core's instruction and data buses. It takes a preload
// phase that fills both arrays, then serves fetches, loads and stores.
module riscv_mem_responder #(
  parameter int unsigned P_DATA_WIDTH      = 32,
  parameter int unsigned P_IMEM_ADDR_WIDTH = 9,
  parameter int unsigned P_DMEM_ADDR_WIDTH = 8,
  parameter int unsigned P_CNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [P_IMEM_ADDR_WIDTH-1:0] inst_addr,
  output logic [P_DATA_WIDTH-1:0]      instr_data,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] data_addr,
  input  logic [P_DATA_WIDTH-1:0]      data_wr,
  input  logic                         data_wr_en_ma,
  output logic [P_DATA_WIDTH-1:0]      data_rd,
  input  logic                         ld_valid,
  input  logic                         ld_sel,
  input  logic [P_IMEM_ADDR_WIDTH-1:0] ld_addr,
  input  logic [P_DATA_WIDTH-1:0]      ld_data,
  input  logic                         ld_done,
  output logic                         ld_ready,
  output logic                         core_hold,
  output logic [P_CNT_WIDTH-1:0]       wr_count
);

  localparam int unsigned IMEM_DEPTH = 1 << P_IMEM_ADDR_WIDTH;
  localparam int unsigned DMEM_DEPTH = 1 << P_DMEM_ADDR_WIDTH;

  typedef enum logic {LOAD, RUN} state_t;

  state_t                  state;
  logic [P_DATA_WIDTH-1:0] imem [IMEM_DEPTH];
  logic [P_DATA_WIDTH-1:0] dmem [DMEM_DEPTH];

  // Arrays have no reset so contents survive it; writes are gated on reset
  // instead, which drops a store that coincides with the reset edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOAD) begin
        if (ld_valid) begin
          if (!ld_sel) imem[ld_addr] <= ld_data;
          else         dmem[ld_addr[P_DMEM_ADDR_WIDTH-1:0]] <= ld_data;
        end
      end else if (data_wr_en_ma) begin
        dmem[data_addr] <= data_wr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      instr_data <= '0;
      data_rd    <= '0;
      wr_count   <= '0;
      ld_ready   <= 1'b1;
      core_hold  <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          if (ld_done) begin
            state     <= RUN;
            ld_ready  <= 1'b0;
            core_hold <= 1'b0;
          end
        end
        RUN: begin
          instr_data <= imem[inst_addr];
          data_rd    <= data_wr_en_ma ? data_wr : dmem[data_addr];
          if (data_wr_en_ma && wr_count != '1)
            wr_count <= wr_count + P_CNT_WIDTH'(1);
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_mem_responder.md
Name: riscv_mem_responder

Overview:
Synthesizable memory responder at the far end of the core's instruction and data memory buses. It returns instructions for fetch addresses and serves loads and stores on the data port. A preload port fills both arrays before the core runs, and the block holds the core in stall until preload completes. It is the memory-side counterpart the core bench instantiates in place of driver-generated responses.

Parameters:
P_DATA_WIDTH, 32, width of instruction and data words
P_IMEM_ADDR_WIDTH, 9, instruction word-address width; IMEM depth = 2**P_IMEM_ADDR_WIDTH words
P_DMEM_ADDR_WIDTH, 8, data word-address width; DMEM depth = 2**P_DMEM_ADDR_WIDTH words
P_CNT_WIDTH, 16, width of the store counter

Ports:
clk  in  1  single clock, all state on posedge
reset  in  1  asynchronous, active-high reset
inst_addr  in  P_IMEM_ADDR_WIDTH  fetch word address from core
instr_data  out  P_DATA_WIDTH  fetched instruction, registered
data_addr  in  P_DMEM_ADDR_WIDTH  load/store word address from core
data_wr  in  P_DATA_WIDTH  store data from core
data_wr_en_ma  in  1  store enable from core (memory-access stage)
data_rd  out  P_DATA_WIDTH  load data, registered
ld_valid  in  1  preload write strobe
ld_sel  in  1  preload target: 0 = IMEM, 1 = DMEM
ld_addr  in  P_IMEM_ADDR_WIDTH  preload word address
ld_data  in  P_DATA_WIDTH  preload word
ld_done  in  1  single-cycle pulse ending preload
ld_ready  out  1  high while preload is accepted
core_hold  out  1  high while the core must stay stalled
wr_count  out  P_CNT_WIDTH  number of core stores since reset, saturating

Behaviour:
- Reset (async, active-high): state <= LOAD. instr_data = 0, data_rd = 0, wr_count = 0, ld_ready = 1, core_hold = 1. Array contents are not cleared and are retained across reset.
- FSM states are LOAD and RUN. LOAD -> RUN on a posedge with ld_done = 1. RUN -> LOAD only via reset.
- LOAD state:
  - On ld_valid, write ld_data to IMEM[ld_addr] when ld_sel = 0.
  - When ld_sel = 1, write ld_data to DMEM[ld_addr[P_DMEM_ADDR_WIDTH-1:0]]; upper bits are ignored.
  - If ld_valid and ld_done are both high in the same cycle, the write is performed and the state still moves to RUN.
  - Core ports are ignored: no store, no counter update, instr_data and data_rd held at 0.
- RUN state:
  - ld_ready = 0, core_hold = 0 (both registered, change on the posedge entering RUN). ld_valid is ignored.
  - Fetch: instr_data <= IMEM[inst_addr] each posedge, 1-cycle latency.
  - Load: data_rd <= DMEM[data_addr] each posedge, 1-cycle latency.
  - Store: if data_wr_en_ma = 1, DMEM[data_addr] <= data_wr. The same-cycle data_rd returns data_wr (write-first).
  - Back-to-back store then load to the same address: the load returns the new value.
  - wr_count increments by 1 per store cycle and saturates at all-ones (no wrap).
- Addresses are word indices. Every value of an address port is in range, so there is no out-of-range case.
- Reset asserted mid-RUN:
  - Outputs clear immediately (async) and the state returns to LOAD.
  - An in-flight store on the reset edge is discarded.
  - Memory is unchanged otherwise.
- X on data_wr_en_ma in RUN is a bench error. The design treats it as no-store; the bench asserts it is never X after leaving LOAD.

Test Plan:
- Reset, then idle with no ld_done: ld_ready = 1, core_hold = 1, instr_data = 0, data_rd = 0 for 10 cycles; a data_wr_en_ma = 1 store to addr 0x05 leaves DMEM[0x05] and wr_count unchanged.
- Preload IMEM[0x000] = 0x00500093 and IMEM[0x1FF] = 0xDEADBEEF, then ld_done; drive inst_addr = 0x1FF -> instr_data = 0xDEADBEEF one cycle later; core_hold = 0 from the cycle after ld_done.
- Preload DMEM[0x10] = 0x12345678 with ld_addr = 0x110 (upper bit ignored); in RUN, load addr 0x10 -> data_rd = 0x12345678.
- In RUN, store 0xCAFEF00D to addr 0x20 -> data_rd = 0xCAFEF00D in the same response cycle; next-cycle load of 0x20 -> 0xCAFEF00D; wr_count = 1.
- ld_valid and ld_done in the same cycle (IMEM[0x003] = 0x11111111) -> word written and state RUN; later ld_valid pulses with ld_data = 0x0 leave IMEM[0x003] = 0x11111111.
- Issue 70000 consecutive stores -> wr_count = 0xFFFF and holds. Assert reset mid-stream -> wr_count = 0, core_hold = 1 asynchronously, and previously stored DMEM words still read back after a new ld_done.
